alu_issue_sequencer: RTL and testbench
======================================

// Module: alu_issue_sequencer
// PURPOSE
//  - Upstream control stage for the 4-bit, 8-op ALU mux: holds a 4-entry x 4-bit register file and accepts instructions over a valid/ready handshake.
//  - Drives ALU operands A/B and the 3-bit select, then writes the combinational ALU result back to a destination register.
//  - Turns the combinational ALU into a usable clocked 4-bit datapath.
// PARAMETERS
//  - DATA_W   4   operand/result width; must equal the ALU width (only 4 supported)
//  - NREG     4   register-file entries (2-bit register addresses)
//  - INSTR_W  10  instruction width
// PORTS
//  - clk        in   1       rising-edge clock
//  - rst_n      in   1       asynchronous active-low reset
//  - in_valid   in   1       instruction present
//  - in_instr   in   10      [9:7] op, [6:5] rd, [4:3] rs, [2:1] rt, [0] reserved; LDI immediate = [4:1]
//  - in_ready   out  1       sequencer can accept (registered)
//  - alu_a      out  4       to ALU A (registered)
//  - alu_b      out  4       to ALU B (registered)
//  - alu_sel    out  3       to ALU select (registered)
//  - alu_result in   4       from ALU output
//  - wb_valid   out  1       one-cycle pulse: register written
//  - wb_addr    out  2       destination of current writeback
//  - wb_data    out  4       value written
//  - dbg_addr   in   2       debug read address
//  - dbg_data   out  4       regfile[dbg_addr], combinational
// BEHAVIOUR
//  - Reset (rst_n low, async): state IDLE; regfile, alu_a, alu_b, wb_addr, wb_data = 0; alu_sel = 3'b000; in_ready = 0; wb_valid = 0.
//  - First clock after reset release: in_ready = 1.
//  - Opcode map (= ALU select): 0 two's-complement of rs; 1 two's-complement of rt; 2 rs+rt; 3 rs-rt; 4 AND; 5 OR; 6 MUL (low 4 bits); 7 LDI (ALU bypassed).
//  - All arithmetic is mod 16; carry and overflow are discarded.
//  - FSM IDLE -> EXEC -> WB -> IDLE. Throughput is one instruction per 3 cycles.
//  - IDLE: accept on in_valid & in_ready at edge T. On accept, latch instr; alu_a = reg[rs], alu_b = reg[rt], alu_sel = op; in_ready -> 0; go to EXEC.
//  - EXEC (T+1): ALU settles; no register changes; go to WB.
//  - WB (T+2): the edge ending WB writes reg[rd] = (op==7) ? imm : alu_result, drives wb_addr/wb_data, sets wb_valid = 1 for one cycle, sets in_ready = 1, goes to IDLE.
//  - wb_valid is high in the cycle after the WB state; the written value is visible on dbg_data in that same cycle.
//  - LDI leaves alu_a, alu_b and alu_sel unchanged from their previous values.
//  - rd equal to rs or rt is legal: operands were captured at accept, so there is no hazard.
//  - A back-to-back dependent instruction sees the new value, because the earliest next accept is after the write.
//  - in_valid while in_ready = 0: ignored; the upstream holds the instruction until accepted.
//  - Reset mid-operation aborts the instruction: no write, all outputs return to reset values.
//  - in_instr[0] is ignored.
// CONFIGURATION
//  - Macro ALU_SEQ_FLAGS_EN defined: adds outputs flag_z (1 bit) and flag_n (1 bit).
//    - Registered, reset 0, updated on every WB from the written value: z = (value==0), n = value[3].
//  - Macro undefined: the flag ports and flag logic are absent; all other behaviour is identical.
// TESTING
//  - Reset, release -> all dbg_data reads 0, wb_valid 0, in_ready 1 one cycle after release.
//  - LDI r1,5; LDI r2,3; ADD r0=r1+r2 -> wb_valid with wb_addr 0, wb_data 4'h8, two cycles after accept; alu_sel 3'b010.
//  - SUB r3=r2-r1 (3-5) -> wb_data 4'hE; NEG(op0) r3=-r1 -> 4'hB.
//  - MUL r0=r1*r2 -> 4'hF; then LDI r1,5, MUL r0=r1*r1 -> 4'h9 (25 mod 16).
//  - in_valid held high continuously with 4 queued instrs -> accepts exactly 3 cycles apart; none dropped or duplicated.
//  - rst_n low during EXEC of ADD r0 -> no wb_valid, r0 stays 0; with ALU_SEQ_FLAGS_EN, SUB r1-r1 -> flag_z 1, flag_n 0.

Source files
------------

// File: rtl/alu_issue_sequencer_if.sv
// Instruction handshake, ALU operand/select drive with result return, and writeback bus
// between the issue sequencer (slave) and its environment (master).
interface alu_issue_sequencer_if #(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned NREG    = 4,
    parameter int unsigned INSTR_W = 10
);
    localparam int unsigned AW = $clog2(NREG);

    logic               in_valid;
    logic [INSTR_W-1:0] in_instr;
    logic               in_ready;
    logic [DATA_W-1:0]  alu_a;
    logic [DATA_W-1:0]  alu_b;
    logic [2:0]         alu_sel;
    logic [DATA_W-1:0]  alu_result;
    logic               wb_valid;
    logic [AW-1:0]      wb_addr;
    logic [DATA_W-1:0]  wb_data;

    modport master (
        output in_valid, in_instr, alu_result,
        input  in_ready, alu_a, alu_b, alu_sel, wb_valid, wb_addr, wb_data
    );

    modport slave (
        input  in_valid, in_instr, alu_result,
        output in_ready, alu_a, alu_b, alu_sel, wb_valid, wb_addr, wb_data
    );
endinterface

// File: rtl/alu_issue_sequencer.sv
// Issue sequencer wrapping a combinational 4-bit ALU: regfile, 3-cycle IDLE/EXEC/WB issue.
// Optional ALU_SEQ_FLAGS_EN adds registered zero/negative flags of each written value.
module alu_issue_sequencer #(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned NREG    = 4,
    parameter int unsigned INSTR_W = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    alu_issue_sequencer_if.slave     bus,
    input  logic [$clog2(NREG)-1:0]  dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic                     flag_z,
    output logic                     flag_n
`endif
);
    localparam int unsigned AW     = $clog2(NREG);
    localparam logic [2:0]  OP_LDI = 3'd7;

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

    state_e              state_q, state_d;
    logic [INSTR_W-1:1]  instr_q, instr_d;
    logic                in_ready_q, in_ready_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [2:0]          alu_sel_q, alu_sel_d;
    logic                wb_valid_q, wb_valid_d;
    logic [AW-1:0]       wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [DATA_W-1:0]   regs_q [NREG];

    logic                wr_en;
    logic [DATA_W-1:0]   wr_data;

    // Bit 0 of the instruction is reserved and deliberately dropped.
    logic unused_rsvd;
    assign unused_rsvd = bus.in_instr[0];

    logic [2:0]    in_op, op_q;
    logic [AW-1:0] in_rs, in_rt, rd_q;
    logic [DATA_W-1:0] imm_q;

    assign in_op = bus.in_instr[9:7];
    assign in_rs = bus.in_instr[4:3];
    assign in_rt = bus.in_instr[2:1];
    assign op_q  = instr_q[9:7];
    assign rd_q  = instr_q[6:5];
    assign imm_q = instr_q[4:1];

    // The ALU result is stable by WB since its inputs were registered at accept.
    assign wr_data = (op_q == OP_LDI) ? imm_q : bus.alu_result;

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        in_ready_d = in_ready_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
        wb_valid_d = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        wr_en      = 1'b0;
        case (state_q)
            StIdle: begin
                in_ready_d = 1'b1;
                if (bus.in_valid && in_ready_q) begin
                    instr_d    = bus.in_instr[INSTR_W-1:1];
                    in_ready_d = 1'b0;
                    state_d    = StExec;
                    if (in_op != OP_LDI) begin
                        alu_a_d   = regs_q[in_rs];
                        alu_b_d   = regs_q[in_rt];
                        alu_sel_d = in_op;
                    end
                end
            end
            StExec: state_d = StWb;
            StWb: begin
                wr_en      = 1'b1;
                wb_valid_d = 1'b1;
                wb_addr_d  = rd_q;
                wb_data_d  = wr_data;
                in_ready_d = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            instr_q    <= '0;
            in_ready_q <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sel_q  <= 3'b000;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            in_ready_q <= in_ready_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sel_q  <= alu_sel_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            if (wr_en) regs_q[rd_q] <= wr_data;
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic flag_z_q, flag_n_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else if (wr_en) begin
            flag_z_q <= (wr_data == '0);
            flag_n_q <= wr_data[DATA_W-1];
        end
    end

    assign flag_z = flag_z_q;
    assign flag_n = flag_n_q;
`endif

    assign bus.in_ready = in_ready_q;
    assign bus.alu_a    = alu_a_q;
    assign bus.alu_b    = alu_b_q;
    assign bus.alu_sel  = alu_sel_q;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_addr  = wb_addr_q;
    assign bus.wb_data  = wb_data_q;
    assign dbg_data     = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Self-checking bench for alu_issue_sequencer: directed spec cases plus randomized
// instruction streams checked against an instruction-level register-file model.
module tb_alu_issue_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;
`ifdef ALU_SEQ_FLAGS_EN
    logic       flag_z, flag_n;
`endif

    alu_issue_sequencer_if bus ();

    alu_issue_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .flag_z   (flag_z),
        .flag_n   (flag_n)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment: the combinational 8-op ALU the sequencer drives.
    function automatic logic [3:0] alu_fn(input logic [2:0] sel, input logic [3:0] a, b);
        case (sel)
            3'd0:    return 4'(0 - int'(a));
            3'd1:    return 4'(0 - int'(b));
            3'd2:    return a + b;
            3'd3:    return a - b;
            3'd4:    return a & b;
            3'd5:    return a | b;
            3'd6:    return 4'(int'(a) * int'(b));
            default: return 4'h0;
        endcase
    endfunction

    always_comb bus.alu_result = alu_fn(bus.alu_sel, bus.alu_a, bus.alu_b);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Instruction-level reference: register values and last-issued ALU operands.
    logic [3:0] mregs [4];
    logic [3:0] m_a, m_b;
    logic [2:0] m_sel;
    int         last_acc;
    logic [3:0] last_wb;

    function automatic logic [3:0] ref_exec(input int op, input int a, input int b,
                                            input int imm);
        int r;
        case (op)
            0:       r = 16 - a;
            1:       r = 16 - b;
            2:       r = a + b;
            3:       r = a - b + 16;
            4:       r = a & b;
            5:       r = a | b;
            6:       r = a * b;
            default: r = imm;
        endcase
        return 4'(r % 16);
    endfunction

    function automatic logic [9:0] mk(input int op, input int rd, input int rs, input int rt);
        return {3'(op), 2'(rd), 2'(rs), 2'(rt), 1'b0};
    endfunction

    function automatic logic [9:0] mk_ldi(input int rd, input int imm);
        return {3'd7, 2'(rd), 4'(imm), 1'b0};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mregs[i] = 4'h0;
        m_a = 4'h0; m_b = 4'h0; m_sel = 3'b000;
    endtask

    task automatic reset_checks(input string tag);
        check_eq({tag, "_rdy"}, bus.in_ready, 0);
        check_eq({tag, "_wbv"}, bus.wb_valid, 0);
        check_eq({tag, "_wba"}, bus.wb_addr, 0);
        check_eq({tag, "_wbd"}, bus.wb_data, 0);
        check_eq({tag, "_a"}, bus.alu_a, 0);
        check_eq({tag, "_b"}, bus.alu_b, 0);
        check_eq({tag, "_sel"}, bus.alu_sel, 0);
`ifdef ALU_SEQ_FLAGS_EN
        check_eq({tag, "_fz"}, flag_z, 0);
        check_eq({tag, "_fn"}, flag_n, 0);
`endif
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1 check_eq({tag, "_reg"}, dbg_data, 0);
        end
    endtask

    // Issue one instruction and follow it to writeback. hold keeps in_valid high afterwards;
    // chk_gap expects the accept exactly 3 cycles after the previous one.
    task automatic send(input logic [9:0] ins, input bit hold, input bit chk_gap);
        int n, op, rd, rs, rt;
        logic [3:0] res;
        bus.in_instr = ins;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_wait", bus.in_ready, 1);
        if (!bus.in_ready) begin
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        op = int'(ins[9:7]); rd = int'(ins[6:5]); rs = int'(ins[4:3]); rt = int'(ins[2:1]);
        res = ref_exec(op, int'(mregs[rs]), int'(mregs[rt]), int'(ins[4:1]));
        if (op != 7) begin
            m_a = mregs[rs]; m_b = mregs[rt]; m_sel = 3'(op);
        end
        if (chk_gap) check_eq("accept_gap", cyc - last_acc, 3);
        last_acc = cyc;
        mregs[rd] = res;
        if (!hold) bus.in_valid = 1'b0;
        check_eq("alu_a", bus.alu_a, m_a);
        check_eq("alu_b", bus.alu_b, m_b);
        check_eq("alu_sel", bus.alu_sel, m_sel);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_eq("wb_early", bus.wb_valid, 0);
            check_eq("rdy_busy", bus.in_ready, 0);
        end
        @(negedge clk);
        check_eq("wb_valid", bus.wb_valid, 1);
        check_eq("wb_addr", bus.wb_addr, rd);
        check_eq("wb_data", bus.wb_data, res);
        check_eq("rdy_after_wb", bus.in_ready, 1);
`ifdef ALU_SEQ_FLAGS_EN
        check_eq("flag_z", flag_z, res == 4'h0);
        check_eq("flag_n", flag_n, res[3]);
`endif
        last_wb  = bus.wb_data;
        dbg_addr = 2'(rd);
        #1 check_eq("dbg_wb", dbg_data, res);
    endtask

    initial begin
        bit hold, prev_hold;
        int idle;
        logic [9:0] ins;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        dbg_addr     = '0;
        rst_n        = 1'b0;
        last_acc     = 0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_checks("rst");
        rst_n = 1'b1;
        #1 check_eq("rdy_at_release", bus.in_ready, 0);
        @(negedge clk);
        check_eq("rdy_first_clk", bus.in_ready, 1);

        // Directed arithmetic cases.
        send(mk_ldi(1, 5), 0, 0);
        send(mk_ldi(2, 3), 0, 0);
        send(mk(2, 0, 1, 2), 0, 0);
        check_eq("add_8", last_wb, 4'h8);
        check_eq("add_sel", bus.alu_sel, 3'b010);
        send(mk(3, 3, 2, 1), 0, 0);
        check_eq("sub_e", last_wb, 4'hE);
        send(mk(0, 3, 1, 0), 0, 0);
        check_eq("neg_b", last_wb, 4'hB);
        send(mk(6, 0, 1, 2), 0, 0);
        check_eq("mul_f", last_wb, 4'hF);
        send(mk_ldi(1, 5), 0, 0);
        check_eq("ldi_keeps_sel", bus.alu_sel, 3'd6);
        send(mk(6, 0, 1, 1), 0, 0);
        check_eq("mul_9", last_wb, 4'h9);

        // Continuous in_valid with four queued instructions.
        send(mk(2, 3, 1, 2), 1, 0);
        send(mk(3, 0, 3, 1), 1, 1);
        send(mk(5, 1, 0, 2), 1, 1);
        send(mk(4, 2, 1, 3), 0, 1);

        // Reset during EXEC of ADD r0 aborts it.
        bus.in_instr = mk(2, 0, 1, 2);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1 reset_checks("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("midrst_no_wb", bus.wb_valid, 0);
        end
        dbg_addr = 2'd0;
        #1 check_eq("midrst_r0", dbg_data, 0);

        // Zero result: r1 - r1.
        send(mk_ldi(1, 7), 0, 0);
        send(mk(3, 1, 1, 1), 0, 0);
        check_eq("sub_self_0", last_wb, 4'h0);
`ifdef ALU_SEQ_FLAGS_EN
        check_eq("sub_self_fz", flag_z, 1);
        check_eq("sub_self_fn", flag_n, 0);
`endif

        // Randomized stream; reserved bit randomized too.
        prev_hold = 1'b0;
        for (int i = 0; i < 80; i++) begin
            ins  = 10'($urandom);
            hold = 1'($urandom);
            send(ins, hold, prev_hold);
            if (!hold) begin
                idle = int'($urandom_range(0, 3));
                repeat (idle) @(negedge clk);
            end
            prev_hold = hold;
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1 check_eq("final_reg", dbg_data, mregs[i]);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
